// File: rtl/mouse_pkg.sv
// Shared types and helpers for the mouse-cursor control path.
package mouse_pkg;

    localparam int POS_W = 12;

    typedef enum logic [1:0] {
        CLICK_NONE,
        CLICK_LEFT,
        CLICK_RIGHT,
        CLICK_BOTH
    } click_t;

    typedef enum logic [1:0] {
        UP,
        WAIT_DN,
        DOWN,
        WAIT_UP
    } btn_state_t;

    // Unsigned clamp of a raw coordinate to [0, lim-1].
    function automatic logic [POS_W-1:0] clamp_pos(input logic [POS_W-1:0] raw,
                                                   input logic [POS_W-1:0] lim);
        return (raw >= lim) ? lim - 1'b1 : raw;
    endfunction

endpackage

// File: rtl/mouse_ctl_btn_debounce.sv
// Button debouncer: a level must hold DEBOUNCE_CYC cycles before it is accepted;
// acceptance of a press emits a one-cycle pulse, releases are silent.
//
// state   | meaning
// UP      | button released and stable
// WAIT_DN | raw went high, counting stable-high cycles
// DOWN    | button pressed and stable
// WAIT_UP | raw went low, counting stable-low cycles
module btn_debounce
    import mouse_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 650000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_TC = CNT_W'(DEBOUNCE_CYC - 1);

    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        press_d = 1'b0;
        case (state_q)
            UP: begin
                if (raw) begin
                    state_d = WAIT_DN;
                    cnt_d   = '0;
                end
            end
            WAIT_DN: begin
                if (!raw) begin
                    state_d = UP;
                end else if (cnt_q == CNT_TC) begin
                    state_d = DOWN;
                    press_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DOWN: begin
                if (!raw) begin
                    state_d = WAIT_UP;
                    cnt_d   = '0;
                end
            end
            WAIT_UP: begin
                if (raw) begin
                    state_d = DOWN;
                end else if (cnt_q == CNT_TC) begin
                    state_d = UP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = UP;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= UP;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/mouse_ctl.sv
// Mouse control top: frame-stable clamped cursor position and a one-deep
// click event register with valid/ready handshake and overrun flag.
module mouse_ctl
    import mouse_pkg::*;
#(
    parameter int H_ACTIVE     = 1024,
    parameter int V_ACTIVE     = 768,
    parameter int DEBOUNCE_CYC = 650000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [POS_W-1:0] xpos_raw,
    input  logic [POS_W-1:0] ypos_raw,
    input  logic             left_raw,
    input  logic             right_raw,
    input  logic             vblnk,
    output logic [POS_W-1:0] mouse_x_pos,
    output logic [POS_W-1:0] mouse_y_pos,
    output logic             click_valid,
    input  logic             click_ready,
    output logic [1:0]       click_type,
    output logic [POS_W-1:0] click_x,
    output logic [POS_W-1:0] click_y,
    output logic             click_overrun
);

    localparam logic [POS_W-1:0] X_LIM = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] Y_LIM = POS_W'(V_ACTIVE);

    logic             press_l, press_r, any_press, vblnk_rise;
    logic             vblnk_d_q;
    logic [POS_W-1:0] mouse_x_q, mouse_x_d, mouse_y_q, mouse_y_d;
    logic             valid_q, valid_d, overrun_q, overrun_d;
    click_t           type_q, type_d;
    logic [POS_W-1:0] click_x_q, click_x_d, click_y_q, click_y_d;

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_left (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (left_raw),
        .press (press_l)
    );

    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_deb_right (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (right_raw),
        .press (press_r)
    );

    assign vblnk_rise = vblnk & ~vblnk_d_q;
    assign any_press  = press_l | press_r;

    always_comb begin
        mouse_x_d = mouse_x_q;
        mouse_y_d = mouse_y_q;
        if (vblnk_rise) begin
            mouse_x_d = clamp_pos(xpos_raw, X_LIM);
            mouse_y_d = clamp_pos(ypos_raw, Y_LIM);
        end
    end

    // The event captures mouse_*_q, so a same-cycle frame load is not yet visible.
    always_comb begin
        valid_d   = valid_q;
        type_d    = type_q;
        click_x_d = click_x_q;
        click_y_d = click_y_q;
        overrun_d = 1'b0;
        if (any_press) begin
            if (!valid_q || click_ready) begin
                valid_d   = 1'b1;
                type_d    = click_t'({press_r, press_l});
                click_x_d = mouse_x_q;
                click_y_d = mouse_y_q;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && click_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_d_q <= 1'b0;
            mouse_x_q <= '0;
            mouse_y_q <= '0;
            valid_q   <= 1'b0;
            type_q    <= CLICK_NONE;
            click_x_q <= '0;
            click_y_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            vblnk_d_q <= vblnk;
            mouse_x_q <= mouse_x_d;
            mouse_y_q <= mouse_y_d;
            valid_q   <= valid_d;
            type_q    <= type_d;
            click_x_q <= click_x_d;
            click_y_q <= click_y_d;
            overrun_q <= overrun_d;
        end
    end

    assign mouse_x_pos   = mouse_x_q;
    assign mouse_y_pos   = mouse_y_q;
    assign click_valid   = valid_q;
    assign click_type    = type_q;
    assign click_x       = click_x_q;
    assign click_y       = click_y_q;
    assign click_overrun = overrun_q;

endmodule
